// File: rtl/sram_piso.sv
// rtl/sram_piso.sv - parallel-in serial-out shifter for SRAM read words
//
// Captures a COLS-wide word on a valid/ready load handshake and presents it
// one bit per accepted shift on serial_out, with frame markers so a SIPO can
// be driven directly (serial_in=serial_out, shift=serial_valid&shift_en,
// load=done).
//
// Ports:
//   clk          rising-edge clock
//   arst_n       asynchronous active-low reset
//   parallel_in  word to serialize, sampled on load handshake
//   load_valid   parallel_in is valid
//   load_ready   block can accept a word (IDLE only)
//   shift_en     downstream consumes the presented bit this cycle
//   abort        synchronous frame cancel, highest priority
//   serial_out   current bit, straight from the shift register output end
//   serial_valid serial_out carries a frame bit
//   serial_first first bit of the frame is presented
//   serial_last  last bit of the frame is presented
//   done         one-cycle pulse after the last bit is consumed
//   busy         frame in progress (same as serial_valid)
module sram_piso #(
  parameter int COLS      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic [COLS-1:0] parallel_in,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            shift_en,
  input  logic            abort,
  output logic            serial_out,
  output logic            serial_valid,
  output logic            serial_first,
  output logic            serial_last,
  output logic            done,
  output logic            busy
);

  localparam int CNT_W = $clog2(COLS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COLS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [COLS-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [COLS-1:0]   shreg_shifted;

  // Move the next bit to the output end, zero fill behind it.
  assign shreg_shifted = MSB_FIRST ? {shreg_q[COLS-2:0], 1'b0}
                                   : {1'b0, shreg_q[COLS-1:1]};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            shreg_d = parallel_in;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            // Shifting on the final bit too leaves the register zero, so
            // serial_out idles low between frames.
            shreg_d = shreg_shifted;
            if (cnt_q == LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign serial_out   = MSB_FIRST ? shreg_q[COLS-1] : shreg_q[0];
  assign serial_valid = (state_q == SHIFT);
  assign busy         = serial_valid;
  assign load_ready   = (state_q == IDLE);
  assign serial_first = serial_valid && (cnt_q == '0);
  assign serial_last  = serial_valid && (cnt_q == LAST);
  assign done         = done_q;

endmodule

// File: tb/tb_sram_piso.sv
// tb/tb_sram_piso.sv - self-checking bench for sram_piso (MSB-first and LSB-first instances)
module tb_sram_piso;

  logic       clk;
  logic       arst_n;

  logic [7:0] pin_m;
  logic       lv_m, se_m, ab_m;
  logic       lr_m, so_m, sv_m, sf_m, sl_m, dn_m, by_m;

  logic [7:0] pin_l;
  logic       lv_l, se_l, ab_l;
  logic       lr_l, so_l, sv_l, sf_l, sl_l, dn_l, by_l;

  int errors = 0;
  int checks = 0;

  sram_piso #(.COLS(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .arst_n(arst_n), .parallel_in(pin_m), .load_valid(lv_m),
    .load_ready(lr_m), .shift_en(se_m), .abort(ab_m), .serial_out(so_m),
    .serial_valid(sv_m), .serial_first(sf_m), .serial_last(sl_m),
    .done(dn_m), .busy(by_m)
  );

  sram_piso #(.COLS(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .arst_n(arst_n), .parallel_in(pin_l), .load_valid(lv_l),
    .load_ready(lr_l), .shift_en(se_l), .abort(ab_l), .serial_out(so_l),
    .serial_valid(sv_l), .serial_first(sf_l), .serial_last(sl_l),
    .done(dn_l), .busy(by_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle past it; inputs are driven and outputs
  // sampled at this point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_m(input logic [7:0] w);
    pin_m = w;
    lv_m  = 1'b1;
    step();
    lv_m  = 1'b0;
  endtask

  // Expected bit i of a frame, straight from the transmit-order rule.
  function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb_first);
    return msb_first ? w[7-i] : w[i];
  endfunction

  task automatic test_reset();
    step(); step();
    arst_n = 1'b0;
    #2;
    checks++;
    if ({so_m, sv_m, sf_m, sl_m, dn_m, by_m, lr_m} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_msb outputs got=%b want=0000001", {so_m, sv_m, sf_m, sl_m, dn_m, by_m, lr_m});
    end
    checks++;
    if ({so_l, sv_l, sf_l, sl_l, dn_l, by_l, lr_l} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_lsb outputs got=%b want=0000001", {so_l, sv_l, sf_l, sl_l, dn_l, by_l, lr_l});
    end
    step();
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({sv_m, dn_m, lr_m, so_m} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_release idle got=%b want=0010", {sv_m, dn_m, lr_m, so_m});
    end
  endtask

  task automatic test_shift_a5();
    logic [7:0] w;
    w = 8'hA5;
    load_m(w);
    se_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (so_m !== exp_bit(w, i, 1'b1)) begin
        errors++;
        $display("FAIL a5_bit%0d got=%b want=%b", i, so_m, exp_bit(w, i, 1'b1));
      end
      checks++;
      if ({sv_m, by_m, lr_m, sf_m, sl_m} !== {1'b1, 1'b1, 1'b0, (i == 0), (i == 7)}) begin
        errors++;
        $display("FAIL a5_flags%0d got=%b want=%b", i, {sv_m, by_m, lr_m, sf_m, sl_m},
                 {1'b1, 1'b1, 1'b0, (i == 0), (i == 7)});
      end
      step();
    end
    checks++;
    if ({dn_m, lr_m, sv_m} !== 3'b110) begin
      errors++;
      $display("FAIL a5_done got=%b want=110", {dn_m, lr_m, sv_m});
    end
    se_m = 1'b0;
    step();
    checks++;
    if (dn_m !== 1'b0) begin
      errors++;
      $display("FAIL a5_done_width got=%b want=0", dn_m);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] w;
    int cyc;
    w = 8'h3C;
    cyc = 0;
    load_m(w);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (so_m !== exp_bit(w, i, 1'b1) || sv_m !== 1'b1) begin
        errors++;
        $display("FAIL bp_bit%0d got=%b/%b want=%b/1", i, so_m, sv_m, exp_bit(w, i, 1'b1));
      end
      se_m = 1'b1;
      step(); cyc++;
      se_m = 1'b0;
      if (i < 7) begin
        checks++;
        if (so_m !== exp_bit(w, i + 1, 1'b1) || sf_m !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold%0d got=%b want=%b", i + 1, so_m, exp_bit(w, i + 1, 1'b1));
        end
        step(); cyc++;
      end
    end
    // Bit 8 is consumed on the 15th edge; done shows after it.
    checks++;
    if (dn_m !== 1'b1 || cyc != 15) begin
      errors++;
      $display("FAIL bp_done got=%b cyc=%0d want=1 cyc=15", dn_m, cyc);
    end
    step();
  endtask

  task automatic test_load_while_busy();
    logic [7:0] w;
    w = 8'hA5;
    load_m(w);
    se_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        pin_m = 8'hFF;
        lv_m  = 1'b1;
        checks++;
        if (lr_m !== 1'b0) begin
          errors++;
          $display("FAIL busy_load_ready got=%b want=0", lr_m);
        end
      end
      checks++;
      if (so_m !== exp_bit(w, i, 1'b1)) begin
        errors++;
        $display("FAIL busy_bit%0d got=%b want=%b", i, so_m, exp_bit(w, i, 1'b1));
      end
      step();
      lv_m = 1'b0;
    end
    checks++;
    if ({dn_m, sv_m} !== 2'b10) begin
      errors++;
      $display("FAIL busy_done got=%b want=10", {dn_m, sv_m});
    end
    se_m = 1'b0;
    step();
  endtask

  task automatic test_abort_and_lsb();
    logic [7:0] w;
    w = 8'hA5;
    load_m(w);
    se_m = 1'b1;
    for (int i = 0; i < 3; i++) step();
    se_m = 1'b0;
    checks++;
    if (so_m !== exp_bit(w, 3, 1'b1) || sv_m !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got=%b want=%b", so_m, exp_bit(w, 3, 1'b1));
    end
    ab_m = 1'b1;
    se_m = 1'b1;
    step();
    ab_m = 1'b0;
    se_m = 1'b0;
    checks++;
    if ({sv_m, lr_m, dn_m, so_m} !== 4'b0100) begin
      errors++;
      $display("FAIL abort_idle got=%b want=0100", {sv_m, lr_m, dn_m, so_m});
    end
    step();
    checks++;
    if ({sv_m, dn_m} !== 2'b00) begin
      errors++;
      $display("FAIL abort_no_done got=%b want=00", {sv_m, dn_m});
    end

    w = 8'h01;
    pin_l = w;
    lv_l  = 1'b1;
    step();
    lv_l  = 1'b0;
    se_l  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (so_l !== exp_bit(w, i, 1'b0) || so_l !== (i == 0) || sf_l !== (i == 0) || sl_l !== (i == 7)) begin
        errors++;
        $display("FAIL lsb_bit%0d got=%b first=%b last=%b want=%b", i, so_l, sf_l, sl_l, (i == 0));
      end
      step();
    end
    checks++;
    if (dn_l !== 1'b1) begin
      errors++;
      $display("FAIL lsb_done got=%b want=1", dn_l);
    end
    se_l = 1'b0;
    step();
  endtask

  task automatic test_loopback();
    logic [7:0] w;
    logic [7:0] sipo;
    int cyc;
    int nbits;
    bit got_done;
    for (int k = 0; k < 100; k++) begin
      w = 8'($urandom);
      sipo = '0;
      nbits = 0;
      cyc = 0;
      got_done = 1'b0;
      checks++;
      if (lr_m !== 1'b1) begin
        errors++;
        $display("FAIL loop_ready frame=%0d got=%b want=1", k, lr_m);
      end
      load_m(w);
      while (!got_done && cyc < 200) begin
        if (dn_m === 1'b1) begin
          got_done = 1'b1;
        end else begin
          if (k == 50 && nbits == 3) begin
            // Mid-frame reset: the partial frame is lost, no done.
            arst_n = 1'b0;
            #1;
            checks++;
            if ({sv_m, dn_m, lr_m} !== 3'b001) begin
              errors++;
              $display("FAIL loop_reset got=%b want=001", {sv_m, dn_m, lr_m});
            end
            se_m = 1'b0;
            step();
            arst_n = 1'b1;
            break;
          end
          se_m = 1'($urandom_range(0, 1));
          if (sv_m && se_m) begin
            sipo = {sipo[6:0], so_m};
            nbits++;
          end
          step();
          cyc++;
        end
      end
      se_m = 1'b0;
      if (k == 50) continue;
      checks++;
      if (!got_done || sipo !== w || nbits != 8) begin
        errors++;
        $display("FAIL loop_frame%0d got=%h bits=%0d done=%b want=%h", k, sipo, nbits, got_done, w);
      end
    end
  endtask

  initial begin
    arst_n = 1'b0;
    pin_m = '0; lv_m = 1'b0; se_m = 1'b0; ab_m = 1'b0;
    pin_l = '0; lv_l = 1'b0; se_l = 1'b0; ab_l = 1'b0;
    #12;
    arst_n = 1'b1;
    test_reset();
    test_shift_a5();
    test_backpressure();
    test_load_while_busy();
    test_abort_and_lsb();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
